// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry hold register; decides whether the shift register reloads
// from the held word or directly from the input (bypass).
module bit_serializer_hold
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_shift,
  input  logic             last_bit,
  input  logic             accept,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             load_shift,
  output logic [WIDTH-1:0] load_word
);

  logic [WIDTH-1:0] data_r;
  logic             full_r;
  logic             push_s;
  logic             pop_s;
  logic             bypass_s;

  // push mid-word, pop at the last-bit edge, bypass when the shifter is free
  always_comb begin
    push_s   = accept && in_shift && !last_bit;
    pop_s    = in_shift && last_bit && full_r;
    bypass_s = accept && (!in_shift || (last_bit && !full_r));
  end

  // hold data and occupancy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
      full_r <= 1'b0;
    end else if (push_s) begin
      data_r <= data_in;
      full_r <= 1'b1;
    end else if (pop_s) begin
      data_r <= '0;
      full_r <= 1'b0;
    end else begin
      data_r <= data_r;
      full_r <= full_r;
    end
  end

  assign full       = full_r;
  assign load_shift = pop_s || bypass_s;
  assign load_word  = pop_s ? data_r : data_in;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so that
// consecutive words stream out without idle gaps.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic             dout_r, dout_s;
  logic             dout_valid_r, dout_valid_s;
  logic             word_done_r, word_done_s;
  logic             hold_full_s;
  logic             load_shift_s;
  logic [WIDTH-1:0] load_word_s;
  logic             accept_s;
  logic             in_shift_s;
  logic             last_bit_s;

  assign load_ready = !hold_full_s && !rst;
  assign accept_s   = load_valid && load_ready;
  assign in_shift_s = (state_r == SHIFT);
  assign last_bit_s = (cnt_r == LAST);
  assign busy       = in_shift_s || hold_full_s;

  bit_serializer_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .in_shift   (in_shift_s),
    .last_bit   (last_bit_s),
    .accept     (accept_s),
    .data_in    (load_data),
    .full       (hold_full_s),
    .load_shift (load_shift_s),
    .load_word  (load_word_s)
  );

  // next state, counter and shifter; outputs are derived from the next
  // values so the registered dout lines up with the shifter contents
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    if (load_shift_s) begin
      state_s = SHIFT;
      cnt_s   = '0;
      shreg_s = load_word_s;
    end else if (in_shift_s) begin
      if (last_bit_s) begin
        state_s = IDLE;
        cnt_s   = '0;
        shreg_s = '0;
      end else begin
        cnt_s   = cnt_r + 1'b1;
        shreg_s = MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0} : {1'b0, shreg_r[WIDTH-1:1]};
      end
    end else begin
      state_s = IDLE;
    end
    dout_valid_s = (state_s == SHIFT);
    dout_s       = dout_valid_s && (MSB_FIRST ? shreg_s[WIDTH-1] : shreg_s[0]);
    word_done_s  = dout_valid_s && (cnt_s == LAST);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shreg_r      <= '0;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      word_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shreg_r      <= shreg_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      word_done_r  <= word_done_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign word_done  = word_done_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one
// stimulus stream; expected bit streams are queued per accepted word.
module tb_bit_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         ready0, dout0, dv0, wd0, busy0;
  logic         ready1, dout1, dv1, wd1, busy1;

  exp_t q0[$];
  exp_t q1[$];
  logic cap[$];
  int   total = 0;
  int   bad   = 0;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready0), .dout(dout0), .dout_valid(dv0), .word_done(wd0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready1), .dout(dout1), .dout_valid(dv1), .word_done(wd1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // expected stream of one word: bit i in transmission order
  task automatic push_word(input int k, input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = (k == 0) ? w[W-1-i] : w[i];
      e.last = (i == W - 1);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // hold is full exactly when more than one word of bits is still pending
  task automatic mon(input int k, input logic rdy, input logic dv, input logic d,
                     input logic wd, input logic bsy);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    check($sformatf("ready%0d", k), 32'(rdy), 32'(n <= W));
    check($sformatf("busy%0d", k), 32'(bsy), 32'(n != 0));
    check($sformatf("dout_valid%0d", k), 32'(dv), 32'(n != 0));
    if (dv && n != 0) begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("dout%0d", k), 32'(d), 32'(e.b));
      check($sformatf("word_done%0d", k), 32'(wd), 32'(e.last));
      if (k == 0) cap.push_back(d);
    end else begin
      check($sformatf("word_done_idle%0d", k), 32'(wd), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ready0, dv0, dout0, wd0, busy0);
      mon(1, ready1, dv1, dout1, wd1, busy1);
    end
  end

  // hold load_valid with a word until the MSB instance takes it
  task automatic offer(input logic [W-1:0] w);
    int n;
    bit a0, a1;
    n = 0;
    @(negedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = w;
    do begin
      if (n > 0) begin
        @(negedge clk);
        #1;
      end
      #1;
      a0 = ready0;
      a1 = ready1;
      @(posedge clk);
      if (a0) push_word(0, w);
      if (a1) push_word(1, w);
      n++;
    end while (!a0 && n < 100);
    if (!a0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nb, guard, hits, p0, p1;
    logic [W-1:0] wv;

    load_valid = 1'b0;
    load_data  = '0;
    rst        = 1'b0;
    #1 rst     = 1'b1;
    #2;
    check("rst_dout_valid", 32'(dv0), 32'd0);
    check("rst_load_ready", 32'(ready0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_word_done", 32'(wd0), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready0), 32'd1);

    // single word, plus a 101 detector on the MSB-first stream
    cap.delete();
    offer(8'hA5);
    idle();
    drain();
    check("a5_len", 32'(cap.size()), 32'd8);
    wv = '0;
    for (int i = 0; i < W; i++) wv = {wv[W-2:0], cap[i]};
    check("a5_bits", 32'(wv), 32'hA5);
    hits = 0; p0 = 0; p1 = 0;
    for (int i = 2; i < cap.size(); i++) begin
      if (cap[i-2] == 1'b1 && cap[i-1] == 1'b0 && cap[i] == 1'b1) begin
        if (hits == 0) p0 = i + 1;
        else           p1 = i + 1;
        hits++;
      end
    end
    check("y_count", 32'(hits), 32'd2);
    check("y_first", 32'(p0), 32'd3);
    check("y_second", 32'(p1), 32'd8);

    // back-to-back and backpressure
    offer(8'hB5);
    offer(8'h5A);
    idle();
    drain();
    offer(8'h3C);
    offer(8'hC3);
    offer(8'h96);
    idle();
    drain();
    offer(8'h01);
    idle();
    drain();

    // random traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else offer(W'($urandom));
    end
    idle();
    drain();

    // reset in the middle of a word
    offer(8'hFF);
    nb = 0;
    guard = 0;
    while (nb < 3 && guard < 20) begin
      @(negedge clk);
      if (dv0) nb++;
      guard++;
      #1 load_valid = 1'b0;
    end
    check("third_bit_seen", 32'(nb), 32'd3);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("midrst_dout_valid", 32'(dv0), 32'd0);
    check("midrst_dout_valid_lsb", 32'(dv1), 32'd0);
    check("midrst_load_ready", 32'(ready0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_dout", 32'(dout0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_ready_after", 32'(ready0), 32'd1);
    repeat (4) @(negedge clk);
    offer(8'h5A);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = LSB first.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 load_data  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  load_data is valid this cycle.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 dout  output  1  serial bit stream; drives din of the downstream mealy_101 detector.
REQ-009 dout_valid  output  1  dout carries a payload bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse coincident with the last bit of each word.
REQ-011 busy  output  1  high while in SHIFT or while the hold register is full.

Function
REQ-012 A word SHALL be accepted on a rising edge where load_valid && load_ready.
REQ-013 Storage SHALL be one shift register plus a one-entry hold register; load_ready = !hold_full, combinational, forced 0 while RST is high.
REQ-014 FSM states: IDLE, SHIFT; the encoding is the package enum.
REQ-015 IDLE: dout=0, dout_valid=0, word_done=0; an accepted word SHALL load directly into the shift register, bit counter = 0, next state SHIFT.
REQ-016 Latency: the first bit of a word accepted in IDLE at edge k SHALL appear on dout, with dout_valid=1, in the cycle following edge k.
REQ-017 SHIFT: dout is the current MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register, dout_valid=1, and each edge shifts by one bit and increments the counter.
REQ-018 Each word SHALL produce exactly WIDTH consecutive dout_valid cycles.
REQ-019 Bit counter width SHALL be $clog2(WIDTH); no wrap occurs, since the counter reloads to 0 at word end.
REQ-020 Accept in SHIFT with the hold register empty, at any edge other than the last-bit edge: the word goes to the hold register and hold_full is set.
REQ-021 Last-bit edge (counter == WIDTH-1), hold full: transfer hold to shift, clear hold_full, counter = 0, stay SHIFT; no idle gap.
REQ-022 Last-bit edge, hold empty, simultaneous accept: the accepted word SHALL bypass hold into shift, counter = 0, stay SHIFT.
REQ-023 Last-bit edge, hold empty, no accept: next state IDLE; dout_valid falls the next cycle.
REQ-024 Last-bit edge, hold full, simultaneous accept: impossible, because load_ready=0.
REQ-025 word_done SHALL be high exactly during the cycle in which the last bit of a word is presented on dout.
REQ-026 dout, dout_valid and word_done SHALL be registered outputs; load_ready and busy are combinational from registered state.
REQ-027 load_data SHALL be ignored whenever load_valid=0 or load_ready=0.

Reset
REQ-028 RST asserted SHALL immediately clear: state=IDLE, hold_full=0, counter=0, shift and hold registers=0, dout=0, dout_valid=0, word_done=0, busy=0.
REQ-029 Reset mid-word SHALL discard the in-flight and held words; no partial word is resumed.
REQ-030 load_ready SHALL become 1 in the first cycle after RST deasserts.

Structure
REQ-031 Package bit_serializer_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the constant DEFAULT_WIDTH=8.
REQ-032 One sub-module, bit_serializer_hold, SHALL implement the one-entry hold register: data, full flag, and push/pop/bypass control.
REQ-033 No other hierarchy is required.

Verification
REQ-034 Single word: WIDTH=8, MSB_FIRST=1, load 8'hA5 from IDLE -> dout 1,0,1,0,0,1,0,1 over 8 dout_valid cycles starting the cycle after accept, word_done on the 8th, then IDLE.
REQ-035 Back-to-back: 8'hB5 then 8'h5A offered continuously -> 16 contiguous dout_valid cycles carrying 10110101 01011010, two word_done pulses 8 cycles apart.
REQ-036 Backpressure: offer 3 words continuously -> load_ready low from the hold-fill edge until the first word's last-bit edge; the third word is accepted exactly then and all 24 bits arrive in order with no gap.
REQ-037 LSB first: MSB_FIRST=0, load 8'h01 -> dout 1,0,0,0,0,0,0,0.
REQ-038 Reset mid-word: assert RST after the 3rd bit of 8'hFF -> dout_valid=0 and load_ready=0 in the same cycle; after release no residual bits, and load_ready=1.
REQ-039 End-to-end: serializer drives mealy_101 din with 8'hA5, MSB first -> Y pulses exactly twice, on bits 3 and 8.
